mem_dcache_if: RTL and testbench
================================

Name: mem_dcache_if

Overview:
- Memory-stage load/store unit between the EX/MEM register and the MEM/WB register.
- Drives the SRAM-like data bus with a req/addr_ok/data_ok handshake.
- Raises a pipeline stall while an access is outstanding.
- Formats load data and handles LL/SC. Produces the result, LLbit update and address-error flags that the MEM/WB register latches.

Parameters:
- ADDR_W, 32, data bus address width.
- DATA_W, 32, data bus and register width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  exception/ERET flush; kills the instruction in MEM
- stall_wb  in  1  ctrl stall[5]; WB stage frozen
- mem_op  in  4  memory op: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW, LL, SC
- alu_result  in  32  effective address for memory ops, or passthrough result
- store_data  in  32  rt value for stores
- llbit  in  1  current LLbit (WB-forwarded)
- data_req  out  1  bus request
- data_wr  out  1  1 = store
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  32  byte address
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  request accepted
- data_rdata  in  32  read data
- data_data_ok  in  1  data returned / write done
- mem_result  out  32  value to MEM/WB wdata
- stallreq  out  1  stall request to ctrl
- llbit_we  out  1  LLbit write enable
- llbit_value  out  1  LLbit write value
- adel  out  1  load address error
- ades  out  1  store address error
- badvaddr  out  32  faulting address

Behaviour:
- Reset:
  - state = IDLE.
  - data_req, data_wr, data_size, data_addr, data_wdata = 0.
  - Registered read-data buffer = 0.
  - stallreq, llbit_we, llbit_value, adel, ades = 0. badvaddr = 0.
  - Reset mid-access abandons it immediately.
- Alignment check (combinational):
  - LH/LHU/SH require addr[0] = 0. LW/SW/LL/SC require addr[1:0] = 0.
  - A misaligned load asserts adel; a misaligned store asserts ades. badvaddr = alu_result.
  - On a misalignment: no bus request, stallreq = 0.
- FSM states:
  - IDLE:
    - Enter ISSUE when mem_op is a memory op, it is aligned, flush = 0, and it is not an SC with llbit = 0.
    - An SC with llbit = 0 completes in IDLE: mem_result = 0, no access, no stall.
  - ISSUE:
    - data_req = 1 with addr/size/wr/wdata held stable until data_addr_ok.
    - On addr_ok go to WAIT.
    - Acceptance in the first ISSUE cycle is legal.
  - WAIT:
    - data_req = 0. On data_ok capture data_rdata into the buffer and go to DONE.
  - DONE:
    - Result is valid from the buffer; stallreq = 0.
    - Go to IDLE when stall_wb = 0; otherwise hold DONE.
  - DRAIN:
    - Entered from ISSUE or WAIT on flush.
    - Completes the handshake (req held until addr_ok, then wait data_ok) and discards the data.
    - Returns to IDLE. The bus req is never withdrawn before addr_ok.
- stallreq:
  - 1 in ISSUE and WAIT.
  - 1 in DRAIN only if mem_op is a memory op; else 0.
  - 0 in IDLE and DONE.
- Latency with zero-wait bus: ISSUE (addr_ok) -> WAIT (data_ok) -> DONE. stallreq is high for 2 cycles; the result is valid in the 3rd.
- flush in DONE or IDLE: go to IDLE next cycle; no bus effect.
- Load formatting (little-endian, lane = addr[1:0]):
  - LB/LBU select byte[lane] and sign/zero-extend.
  - LH/LHU select half[addr[1]] and sign/zero-extend.
  - LW/LL pass the word through.
- Store data: SB replicates the byte ×4, SH replicates the half ×2, SW/SC send the word.
- LL: llbit_we = 1 and llbit_value = 1 in DONE.
- SC: llbit_we = 1 and llbit_value = 0 on completion. mem_result = 1 on a successful store, 0 on a skip.
- Non-memory op: mem_result = alu_result combinationally, stallreq = 0.
- flush overrides every other output: llbit_we, adel and ades = 0.

Decomposition:
- Shared package mem_defs.vh:
  - mem_op encodings (NONE = 0 … SC = 10).
  - FSM state encodings (IDLE, ISSUE, WAIT, DONE, DRAIN).
  - Size codes.
- One combinational sub-module, mem_load_fmt (lane select plus extension), is natural. The FSM and store formatting stay in the top.

Test Plan:
- LB, addr 0x1003, rdata 0x80FF_0000, zero-wait bus -> data_size = 0; stallreq high for 2 cycles; mem_result = 0xFFFF_FF80. Repeat with LBU -> 0x0000_0080.
- SH, addr 0x2002, store_data 0x1234_ABCD, addr_ok delayed 3 cycles -> data_req stays high 4 cycles with data_wdata = 0xABCD_ABCD and size = 1; stallreq high until data_ok.
- LW, addr 0x3001 -> adel = 1, badvaddr = 0x3001, data_req never asserted, stallreq = 0.
- LL at 0x4000 then SC at 0x4000 with llbit = 1 -> SC issues a bus write and mem_result = 1, llbit_we with value 0. SC with llbit = 0 -> no data_req, mem_result = 0, no stall.
- flush during WAIT of an LW -> FSM enters DRAIN and discards data_ok data; a following NONE op sees stallreq = 0 and mem_result = alu_result.
- stall_wb = 1 while in DONE for 2 cycles -> mem_result stays stable, stallreq = 0; FSM leaves DONE only when stall_wb drops. rst asserted in WAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mem_dcache_if_pkg.sv
// Shared encodings for the memory-stage load/store unit: op codes, FSM states,
// bus size codes and small op-classification helpers.
package mem_dcache_if_pkg;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_LH   = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;
  localparam logic [3:0] OP_LL   = 4'd9;
  localparam logic [3:0] OP_SC   = 4'd10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW) || (op == OP_LL);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SC);
  endfunction

  function automatic logic [1:0] op_size(input logic [3:0] op);
    logic [1:0] sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
      default:              sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    if (op_is_load(op) || op_is_store(op)) begin
      case (op_size(op))
        SZ_HALF: bad = lo[0];
        SZ_WORD: bad = |lo;
        default: bad = 1'b0;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/mem_dcache_if_load_fmt.sv
// Little-endian load formatter: selects the byte/half lane of the returned word
// and sign- or zero-extends it according to the load op.
module mem_load_fmt
  import mem_dcache_if_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        op,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] result
);

  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_sel = rdata[7:0];
    case (lane)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    byte_s   = byte_sel;
    half_s   = half_sel;
    case (op)
      OP_LB:   result = DATA_W'(byte_s);
      OP_LBU:  result = DATA_W'(byte_sel);
      OP_LH:   result = DATA_W'(half_s);
      OP_LHU:  result = DATA_W'(half_sel);
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_dcache_if.sv
// Memory-stage load/store unit: drives the req/addr_ok/data_ok data bus, stalls
// the pipeline while an access is outstanding, formats loads and handles LL/SC.
module mem_dcache_if
  import mem_dcache_if_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall_wb,
  input  logic [3:0]        mem_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic              llbit,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic [DATA_W-1:0] data_rdata,
  input  logic              data_data_ok,
  output logic [DATA_W-1:0] mem_result,
  output logic              stallreq,
  output logic              llbit_we,
  output logic              llbit_value,
  output logic              adel,
  output logic              ades,
  output logic [DATA_W-1:0] badvaddr
);

  logic [2:0]        state, state_nxt;
  logic              drain_acc, drain_acc_nxt;
  logic [3:0]        op_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [1:0]        size_p1;
  logic              wr_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic [DATA_W-1:0] rbuf_p1;

  logic              is_ld, is_st, is_mem, misalign, sc_skip, start, issue_live;
  logic [1:0]        size_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] load_val;

  assign is_ld      = op_is_load(mem_op);
  assign is_st      = op_is_store(mem_op);
  assign is_mem     = is_ld || is_st;
  assign misalign   = op_misaligned(mem_op, alu_result[1:0]);
  assign sc_skip    = (mem_op == OP_SC) && !llbit && !misalign;
  assign start      = (state == ST_IDLE) && is_mem && !misalign && !flush && !sc_skip;
  // The first request cycle is driven straight from EX/MEM; later ones replay the latched copy.
  assign issue_live = (state == ST_ISSUE) || ((state == ST_DRAIN) && !drain_acc);
  assign size_c     = op_size(mem_op);

  always_comb begin
    case (size_c)
      SZ_BYTE: wdata_c = {4{store_data[7:0]}};
      SZ_HALF: wdata_c = {2{store_data[15:0]}};
      default: wdata_c = store_data;
    endcase
  end

  always_comb begin
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = 2'd0;
    data_addr  = '0;
    data_wdata = '0;
    if (start) begin
      data_req   = 1'b1;
      data_wr    = is_st;
      data_size  = size_c;
      data_addr  = alu_result[ADDR_W-1:0];
      data_wdata = wdata_c;
    end else if (issue_live) begin
      data_req   = 1'b1;
      data_wr    = wr_p1;
      data_size  = size_p1;
      data_addr  = addr_p1;
      data_wdata = wdata_p1;
    end
  end

  always_comb begin
    state_nxt     = state;
    drain_acc_nxt = drain_acc;
    case (state)
      ST_IDLE:
        if (start) state_nxt = data_addr_ok ? ST_WAIT : ST_ISSUE;
      ST_ISSUE:
        if (flush) begin
          state_nxt     = ST_DRAIN;
          drain_acc_nxt = data_addr_ok;
        end else if (data_addr_ok) begin
          state_nxt = ST_WAIT;
        end
      ST_WAIT:
        if (flush) begin
          state_nxt     = data_data_ok ? ST_IDLE : ST_DRAIN;
          drain_acc_nxt = 1'b1;
        end else if (data_data_ok) begin
          state_nxt = ST_DONE;
        end
      ST_DONE:
        if (flush || !stall_wb) state_nxt = ST_IDLE;
      ST_DRAIN:
        if (!drain_acc) begin
          if (data_addr_ok) drain_acc_nxt = 1'b1;
        end else if (data_data_ok) begin
          state_nxt = ST_IDLE;
        end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // p1: request latched at issue, read data latched on data_ok
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      drain_acc <= 1'b0;
      op_p1     <= OP_NONE;
      addr_p1   <= '0;
      size_p1   <= 2'd0;
      wr_p1     <= 1'b0;
      wdata_p1  <= '0;
      rbuf_p1   <= '0;
    end else begin
      state     <= state_nxt;
      drain_acc <= drain_acc_nxt;
      if (start) begin
        op_p1    <= mem_op;
        addr_p1  <= alu_result[ADDR_W-1:0];
        size_p1  <= size_c;
        wr_p1    <= is_st;
        wdata_p1 <= wdata_c;
      end
      if ((state == ST_WAIT) && data_data_ok && !flush) rbuf_p1 <= data_rdata;
    end
  end

  mem_load_fmt #(.DATA_W(DATA_W)) u_load_fmt (
    .op     (op_p1),
    .lane   (addr_p1[1:0]),
    .rdata  (rbuf_p1),
    .result (load_val)
  );

  // p2: result, stall and exception outputs
  always_comb begin
    stallreq    = start || (state == ST_ISSUE) || (state == ST_WAIT) ||
                  ((state == ST_DRAIN) && is_mem);
    mem_result  = alu_result;
    llbit_we    = 1'b0;
    llbit_value = 1'b0;
    if ((state == ST_IDLE) && sc_skip) begin
      mem_result = '0;
      llbit_we   = 1'b1;
    end else if (state == ST_DONE) begin
      if (op_p1 == OP_SC) begin
        mem_result = DATA_W'(1);
        llbit_we   = 1'b1;
      end else if (op_is_load(op_p1)) begin
        mem_result = load_val;
        if (op_p1 == OP_LL) begin
          llbit_we    = 1'b1;
          llbit_value = 1'b1;
        end
      end
    end
    adel = !flush && (state == ST_IDLE) && is_ld && misalign;
    ades = !flush && (state == ST_IDLE) && is_st && misalign;
    if (flush) llbit_we = 1'b0;
    badvaddr = (adel || ades) ? alu_result : '0;
  end

endmodule

// File: tb/tb_mem_dcache_if.sv
// Directed bench for mem_dcache_if with a small configurable-latency bus responder.
module tb_mem_dcache_if;
  import mem_dcache_if_pkg::*;

  logic        clk, rst, flush, stall_wb, llbit;
  logic [3:0]  mem_op;
  logic [31:0] alu_result, store_data;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [31:0] mem_result, badvaddr;
  logic        stallreq, llbit_we, llbit_value, adel, ades;

  int checks = 0;
  int failures = 0;

  int   addr_delay = 0;
  int   data_delay = 0;
  int   req_cnt = 0;
  int   pend_cnt = 0;
  logic pend = 1'b0;

  int          r_stalls, r_reqs;
  logic [31:0] r_res, r_wd, r_ad, r_bad;
  logic [1:0]  r_sz;
  logic        r_wr, r_lwe, r_lval, r_adel, r_ades;

  mem_dcache_if dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_wb(stall_wb),
    .mem_op(mem_op), .alu_result(alu_result), .store_data(store_data), .llbit(llbit),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_rdata(data_rdata), .data_data_ok(data_data_ok),
    .mem_result(mem_result), .stallreq(stallreq), .llbit_we(llbit_we),
    .llbit_value(llbit_value), .adel(adel), .ades(ades), .badvaddr(badvaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign data_addr_ok = data_req && (req_cnt >= addr_delay);
  assign data_data_ok = pend && (pend_cnt >= data_delay);

  always @(posedge clk) begin
    if (rst) begin
      req_cnt  <= 0;
      pend     <= 1'b0;
      pend_cnt <= 0;
    end else begin
      if (data_req && !data_addr_ok) req_cnt <= req_cnt + 1;
      else                           req_cnt <= 0;
      if (data_req && data_addr_ok) begin
        pend     <= 1'b1;
        pend_cnt <= 0;
      end else if (data_data_ok) begin
        pend <= 1'b0;
      end else if (pend) begin
        pend_cnt <= pend_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata);
    int n;
    mem_op = op; alu_result = addr; store_data = sdata;
    r_stalls = 0; r_reqs = 0; r_sz = 2'd3; r_wd = 32'h0; r_wr = 1'b0; r_ad = 32'h0; n = 0;
    #1;
    while (stallreq && n < 30) begin
      r_stalls++;
      if (data_req) begin
        r_reqs++; r_sz = data_size; r_wd = data_wdata; r_wr = data_wr; r_ad = data_addr;
      end
      cyc(); #1; n++;
    end
    if (n >= 30) chk("timeout_stallreq", 32'(stallreq), 32'h0);
    if (data_req) r_reqs++;
    r_res = mem_result; r_lwe = llbit_we; r_lval = llbit_value;
    r_adel = adel; r_ades = ades; r_bad = badvaddr;
    cyc();
    mem_op = OP_NONE; alu_result = 32'h0; store_data = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; stall_wb = 1'b0; llbit = 1'b0;
    mem_op = OP_NONE; alu_result = 32'h0; store_data = 32'h0; data_rdata = 32'h0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst_req", 32'(data_req), 32'h0);
    chk("rst_stall", 32'(stallreq), 32'h0);
    chk("rst_result", mem_result, 32'h0);
    chk("rst_llwe", 32'(llbit_we), 32'h0);
    chk("rst_adel", 32'(adel), 32'h0);
    chk("rst_addr", data_addr, 32'h0);
    cyc();

    // LB / LBU, zero-wait bus
    data_rdata = 32'h80FF_0000;
    run_op(OP_LB, 32'h1003, 32'h0);
    chk("lb_stalls", 32'(r_stalls), 32'd2);
    chk("lb_size", 32'(r_sz), 32'd0);
    chk("lb_wr", 32'(r_wr), 32'h0);
    chk("lb_result", r_res, 32'hFFFF_FF80);
    run_op(OP_LBU, 32'h1003, 32'h0);
    chk("lbu_result", r_res, 32'h0000_0080);

    // SH with addr_ok delayed 3 cycles
    addr_delay = 3;
    run_op(OP_SH, 32'h2002, 32'h1234_ABCD);
    chk("sh_reqs", 32'(r_reqs), 32'd4);
    chk("sh_wdata", r_wd, 32'hABCD_ABCD);
    chk("sh_size", 32'(r_sz), 32'd1);
    chk("sh_addr", r_ad, 32'h2002);
    chk("sh_stalls", 32'(r_stalls), 32'd5);
    addr_delay = 0;

    // SB lane replication
    run_op(OP_SB, 32'h0010, 32'h0000_00A5);
    chk("sb_wdata", r_wd, 32'hA5A5_A5A5);

    // misaligned load and store
    run_op(OP_LW, 32'h3001, 32'h0);
    chk("lw_mis_adel", 32'(r_adel), 32'h1);
    chk("lw_mis_bad", r_bad, 32'h3001);
    chk("lw_mis_reqs", 32'(r_reqs), 32'd0);
    chk("lw_mis_stall", 32'(r_stalls), 32'd0);
    run_op(OP_SW, 32'h0002, 32'h0);
    chk("sw_mis_ades", 32'(r_ades), 32'h1);

    // LH signed upper half
    data_rdata = 32'hBEEF_1234;
    run_op(OP_LH, 32'h7002, 32'h0);
    chk("lh_result", r_res, 32'hFFFF_BEEF);

    // LL then SC with llbit=1, then SC with llbit=0
    data_rdata = 32'hDEAD_BEEF;
    run_op(OP_LL, 32'h4000, 32'h0);
    chk("ll_result", r_res, 32'hDEAD_BEEF);
    chk("ll_we", 32'(r_lwe), 32'h1);
    chk("ll_val", 32'(r_lval), 32'h1);
    llbit = 1'b1;
    run_op(OP_SC, 32'h4000, 32'h0000_0055);
    chk("sc_wr", 32'(r_wr), 32'h1);
    chk("sc_result", r_res, 32'h1);
    chk("sc_we", 32'(r_lwe), 32'h1);
    chk("sc_val", 32'(r_lval), 32'h0);
    llbit = 1'b0;
    run_op(OP_SC, 32'h4000, 32'h0000_0055);
    chk("scskip_reqs", 32'(r_reqs), 32'd0);
    chk("scskip_stall", 32'(r_stalls), 32'd0);
    chk("scskip_result", r_res, 32'h0);
    chk("scskip_we", 32'(r_lwe), 32'h1);

    // flush during WAIT of an LW: drained, then next ops unaffected
    data_delay = 2;
    data_rdata = 32'h1111_2222;
    mem_op = OP_LW; alu_result = 32'h5000;
    cyc();
    flush = 1'b1;
    #1;
    chk("fl_wait_stall", 32'(stallreq), 32'h1);
    chk("fl_wait_llwe", 32'(llbit_we), 32'h0);
    cyc();
    flush = 1'b0; mem_op = OP_NONE; alu_result = 32'h0000_0077;
    #1;
    chk("fl_none_stall", 32'(stallreq), 32'h0);
    chk("fl_none_result", mem_result, 32'h0000_0077);
    chk("fl_none_req", 32'(data_req), 32'h0);
    cyc();
    mem_op = OP_LW; alu_result = 32'h6000;
    #1;
    chk("fl_drain_stall", 32'(stallreq), 32'h1);
    chk("fl_drain_req", 32'(data_req), 32'h0);
    cyc();
    data_delay = 0;
    data_rdata = 32'hCAFE_F00D;
    run_op(OP_LW, 32'h6000, 32'h0);
    chk("fl_next_stalls", 32'(r_stalls), 32'd2);
    chk("fl_next_result", r_res, 32'hCAFE_F00D);

    // stall_wb holds DONE for two cycles
    data_rdata = 32'hBEEF_1234;
    stall_wb = 1'b1;
    mem_op = OP_LHU; alu_result = 32'h7002;
    cyc(); cyc();
    #1;
    chk("swb_done_stall", 32'(stallreq), 32'h0);
    chk("swb_done_result", mem_result, 32'h0000_BEEF);
    cyc();
    #1;
    chk("swb_hold_result", mem_result, 32'h0000_BEEF);
    chk("swb_hold_req", 32'(data_req), 32'h0);
    cyc();
    stall_wb = 1'b0;
    #1;
    chk("swb_rel_stall", 32'(stallreq), 32'h0);
    chk("swb_rel_result", mem_result, 32'h0000_BEEF);
    cyc();
    mem_op = OP_NONE; alu_result = 32'h0000_0099;
    #1;
    chk("swb_idle_result", mem_result, 32'h0000_0099);
    cyc();

    // reset while waiting for data
    data_delay = 3;
    mem_op = OP_LW; alu_result = 32'h8000;
    cyc();
    rst = 1'b1; mem_op = OP_NONE; alu_result = 32'h0;
    cyc();
    rst = 1'b0;
    #1;
    chk("rstw_req", 32'(data_req), 32'h0);
    chk("rstw_stall", 32'(stallreq), 32'h0);
    chk("rstw_result", mem_result, 32'h0);
    chk("rstw_llwe", 32'(llbit_we), 32'h0);
    chk("rstw_bad", badvaddr, 32'h0);
    cyc();
    data_delay = 0;

    // flush on a misaligned op in IDLE suppresses everything
    flush = 1'b1; mem_op = OP_LW; alu_result = 32'h9001;
    #1;
    chk("fl_idle_adel", 32'(adel), 32'h0);
    chk("fl_idle_req", 32'(data_req), 32'h0);
    chk("fl_idle_stall", 32'(stallreq), 32'h0);
    cyc();
    flush = 1'b0; mem_op = OP_NONE; alu_result = 32'h0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
